dac_mix_scheduler: RTL and testbench
====================================

Name: dac_mix_scheduler

Overview:
Time-multiplexed audio mix sequencer in front of the board DAC. A base-rate enable divided by DAC_FREQ_DIV starts each sample period. Every period the block snapshots NUM_SRC signed sound-source outputs and multiply-accumulates them serially through one shared MAC with per-source volume and mute. It then saturates the sum and presents an offset-binary DAC_BIT_WIDTH code to the DAC modulator. It also owns the sample-rate schedule and reports overruns.

Parameters:
NUM_SRC, 4, number of sound sources mixed (1..8)
SRC_WIDTH, 16, signed source sample width
VOL_WIDTH, 4, unsigned per-source volume width; gain = vol / 2^VOL_WIDTH
DAC_BIT_WIDTH, 10, DAC code width (<= SRC_WIDTH)
DAC_FREQ_DIV, 5, TICK_EN pulses per sample period (>= 1)

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous reset, active-high
TICK_EN  in  1  base-rate enable, one-cycle pulses
SRC_DATA  in  NUM_SRC*SRC_WIDTH  signed samples; source i at [i*SRC_WIDTH +: SRC_WIDTH]
SRC_VOL  in  NUM_SRC*VOL_WIDTH  per-source volume, same packing
SRC_MUTE  in  NUM_SRC  1 = source contributes 0
OVERRUN_CLR  in  1  clears OVERRUN
SAMPLE_REQ  out  1  one-cycle pulse in SNAP; sources may advance
DAC_VALUE  out  DAC_BIT_WIDTH  offset-binary DAC code
DAC_STROBE  out  1  one-cycle pulse when DAC_VALUE updates
BUSY  out  1  high whenever state != IDLE
OVERRUN  out  1  sticky: a sample start was dropped

Behaviour:
- Clocking and reset: single clock CLK; reset RESET is synchronous and active-high. All state is sampled on the CLK rising edge.
- Reset values: DAC_VALUE = 2^(DAC_BIT_WIDTH-1) (midscale, 512). SAMPLE_REQ, DAC_STROBE, BUSY and OVERRUN = 0. Divider = 0. State = IDLE. Accumulator = 0.
- Reset mid-operation: the partial sum is discarded, no strobe is issued, and DAC_VALUE returns to midscale.
- Divider:
  - div_cnt increments on TICK_EN.
  - When TICK_EN is high and div_cnt == DAC_FREQ_DIV-1, div_cnt wraps to 0 and a start is raised that cycle.
  - DAC_FREQ_DIV = 1 gives a start on every TICK_EN.
- FSM states: IDLE, SNAP, MAC, OUT.
  - IDLE -> SNAP on start.
  - SNAP: latch SRC_DATA, SRC_VOL and SRC_MUTE into snapshot registers; clear the accumulator; idx = 0; SAMPLE_REQ = 1. -> MAC.
  - MAC: acc += mute[idx] ? 0 : data[idx] * vol[idx] (signed × zero-extended unsigned). Advance one source per cycle. -> OUT after idx == NUM_SRC-1.
  - OUT: compute the DAC code, register DAC_VALUE, pulse DAC_STROBE for one cycle. -> IDLE.
- Latency: start on edge t puts SNAP at t+1, MAC at t+2 .. t+1+NUM_SRC, OUT at t+2+NUM_SRC. DAC_VALUE and DAC_STROBE are visible from t+3+NUM_SRC (7 edges at NUM_SRC = 4). BUSY covers NUM_SRC+2 cycles.
- Arithmetic:
  - acc width = SRC_WIDTH + VOL_WIDTH + clog2(NUM_SRC) + 1, signed; it can never overflow.
  - mix = acc >>> VOL_WIDTH (arithmetic shift, floor).
  - Saturate mix to [-2^(SRC_WIDTH-1), 2^(SRC_WIDTH-1)-1].
  - Take the top DAC_BIT_WIDTH bits and invert the MSB to give offset binary.
- Input changes after SNAP do not affect the current sample.
- Overrun:
  - A start while BUSY is dropped and sets OVERRUN. The divider keeps counting.
  - OVERRUN_CLR clears OVERRUN; if set and clear occur in the same cycle, set wins.
- TICK_EN during reset is ignored.

Test Plan:
- Reset: assert RESET 3 cycles -> DAC_VALUE = 512, DAC_STROBE = 0, BUSY = 0, OVERRUN = 0, SAMPLE_REQ = 0.
- Scheduling: TICK_EN every 4th clock, DIV = 5 -> SAMPLE_REQ every 20 clocks. DAC_STROBE exactly 6 clocks after each SAMPLE_REQ. OVERRUN stays 0.
- Single source: src0 = 0x4000, vol0 = 15, others muted -> mix 0x3C00, DAC_VALUE = 752. Src1 = -0x2000, vol1 = 8 alone -> mix = -4096, DAC_VALUE = 448.
- Saturation: all four sources 0x7FFF, vol = 15 -> DAC_VALUE = 1023. All 0x8000, vol = 15 -> DAC_VALUE = 0.
- Snapshot/mute: change src0 from 0x4000 to 0x7FFF during MAC -> output still 752. Mute src0 with 0x7FFF and vol = 15 -> contributes 0.
- Overrun/reset:
  - TICK_EN held high, DIV = 5 (period 5 < 6 busy) -> second start dropped, OVERRUN = 1.
  - OVERRUN_CLR and a new overrun in the same cycle -> OVERRUN stays 1.
  - RESET during MAC -> no strobe, DAC_VALUE = 512, BUSY = 0 next cycle.

Source files
------------

// File: rtl/dac_mix_scheduler.sv
// Audio mix sequencer: divides TICK_EN into sample periods, serially MACs the
// snapshotted sources through one multiplier and drives a saturated offset-binary DAC code.
module dac_mix_scheduler #(
   parameter int NUM_SRC       = 4,
   parameter int SRC_WIDTH     = 16,
   parameter int VOL_WIDTH     = 4,
   parameter int DAC_BIT_WIDTH = 10,
   parameter int DAC_FREQ_DIV  = 5
) (
   input  logic                           CLK,
   input  logic                           RESET,
   input  logic                           TICK_EN,
   input  logic [NUM_SRC*SRC_WIDTH-1:0]   SRC_DATA,
   input  logic [NUM_SRC*VOL_WIDTH-1:0]   SRC_VOL,
   input  logic [NUM_SRC-1:0]             SRC_MUTE,
   input  logic                           OVERRUN_CLR,
   output logic                           SAMPLE_REQ,
   output logic [DAC_BIT_WIDTH-1:0]       DAC_VALUE,
   output logic                           DAC_STROBE,
   output logic                           BUSY,
   output logic                           OVERRUN
);

   localparam int AW = SRC_WIDTH + VOL_WIDTH + $clog2(NUM_SRC) + 1;
   localparam int PW = SRC_WIDTH + VOL_WIDTH + 1;
   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int DW = (DAC_FREQ_DIV > 1) ? $clog2(DAC_FREQ_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DAC_FREQ_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_SRC - 1);
   localparam logic [DAC_BIT_WIDTH-1:0] MIDSCALE = {1'b1, {(DAC_BIT_WIDTH-1){1'b0}}};
   localparam logic signed [AW-1:0] SAT_HI = {{(AW-SRC_WIDTH+1){1'b0}}, {(SRC_WIDTH-1){1'b1}}};
   localparam logic signed [AW-1:0] SAT_LO = {{(AW-SRC_WIDTH+1){1'b1}}, {(SRC_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SNAP, MAC, OUT} state_t;

   state_t                      state;
   logic [DW-1:0]               div_cnt;
   logic                        start;
   logic signed [SRC_WIDTH-1:0] snap_data [NUM_SRC];
   logic [VOL_WIDTH-1:0]        snap_vol  [NUM_SRC];
   logic [NUM_SRC-1:0]          snap_mute;
   logic [IW-1:0]               idx;
   logic signed [AW-1:0]        acc;
   logic signed [AW-1:0]        term;
   logic signed [AW-1:0]        mix;
   logic signed [PW-1:0]        prod;
   logic signed [SRC_WIDTH-1:0] sat;
   logic [DAC_BIT_WIDTH-1:0]    code;

   assign start = TICK_EN && (div_cnt == DIV_LAST);

   // Volume is unsigned: a zero MSB makes the signed multiply treat it as non-negative.
   always_comb begin
      prod = PW'(snap_data[idx]) * PW'($signed({1'b0, snap_vol[idx]}));
      term = snap_mute[idx] ? '0 : AW'(prod);
   end

   always_comb begin
      mix = acc >>> VOL_WIDTH;
      if (mix > SAT_HI)
         sat = {1'b0, {(SRC_WIDTH-1){1'b1}}};
      else if (mix < SAT_LO)
         sat = {1'b1, {(SRC_WIDTH-1){1'b0}}};
      else
         sat = mix[SRC_WIDTH-1:0];
      code = {~sat[SRC_WIDTH-1], sat[SRC_WIDTH-2 -: DAC_BIT_WIDTH-1]};
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         div_cnt    <= '0;
         acc        <= '0;
         idx        <= '0;
         SAMPLE_REQ <= 1'b0;
         DAC_STROBE <= 1'b0;
         BUSY       <= 1'b0;
         OVERRUN    <= 1'b0;
         DAC_VALUE  <= MIDSCALE;
      end else begin
         SAMPLE_REQ <= 1'b0;
         DAC_STROBE <= 1'b0;

         if (TICK_EN)
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);

         // A start arriving while busy is dropped; a new overrun beats a same-cycle clear.
         OVERRUN <= (start && (state != IDLE)) || (OVERRUN && !OVERRUN_CLR);

         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SNAP;
                  SAMPLE_REQ <= 1'b1;
                  BUSY       <= 1'b1;
               end
            end
            SNAP: begin
               for (int unsigned i = 0; i < NUM_SRC; i++) begin
                  snap_data[i] <= SRC_DATA[i*SRC_WIDTH +: SRC_WIDTH];
                  snap_vol[i]  <= SRC_VOL[i*VOL_WIDTH +: VOL_WIDTH];
               end
               snap_mute <= SRC_MUTE;
               acc       <= '0;
               idx       <= '0;
               state     <= MAC;
            end
            MAC: begin
               acc <= acc + term;
               if (idx == IDX_LAST)
                  state <= OUT;
               else
                  idx <= idx + IW'(1);
            end
            OUT: begin
               DAC_VALUE  <= code;
               DAC_STROBE <= 1'b1;
               BUSY       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_mix_scheduler.sv
// Scoreboard bench for dac_mix_scheduler: expected codes are queued when a
// snapshot is requested and compared when the DAC strobe arrives.
module tb_dac_mix_scheduler;

   localparam int NS  = 4;
   localparam int SW  = 16;
   localparam int VW  = 4;
   localparam int DBW = 10;
   localparam int DIV = 5;

   logic               CLK = 1'b0;
   logic               RESET = 1'b1;
   logic               TICK_EN = 1'b0;
   logic               OVERRUN_CLR = 1'b0;
   logic [NS*SW-1:0]   SRC_DATA = '0;
   logic [NS*VW-1:0]   SRC_VOL = '0;
   logic [NS-1:0]      SRC_MUTE = '1;
   logic               SAMPLE_REQ;
   logic [DBW-1:0]     DAC_VALUE;
   logic               DAC_STROBE;
   logic               BUSY;
   logic               OVERRUN;

   dac_mix_scheduler #(
      .NUM_SRC(NS), .SRC_WIDTH(SW), .VOL_WIDTH(VW),
      .DAC_BIT_WIDTH(DBW), .DAC_FREQ_DIV(DIV)
   ) dut (
      .CLK(CLK), .RESET(RESET), .TICK_EN(TICK_EN),
      .SRC_DATA(SRC_DATA), .SRC_VOL(SRC_VOL), .SRC_MUTE(SRC_MUTE),
      .OVERRUN_CLR(OVERRUN_CLR), .SAMPLE_REQ(SAMPLE_REQ),
      .DAC_VALUE(DAC_VALUE), .DAC_STROBE(DAC_STROBE),
      .BUSY(BUSY), .OVERRUN(OVERRUN)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int exp_q[$];
   int req_q[$];
   int n_strobe = 0;
   int n_req = 0;
   int last_req = -1;
   bit chk_period = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int model(input logic [NS*SW-1:0] d, input logic [NS*VW-1:0] v,
                                input logic [NS-1:0] m);
      longint acc;
      longint mix;
      acc = 0;
      for (int i = 0; i < NS; i++)
         if (!m[i])
            acc += longint'($signed(d[i*SW +: SW])) * longint'(v[i*VW +: VW]);
      mix = acc >>> VW;
      if (mix > 32767) mix = 32767;
      if (mix < -32768) mix = -32768;
      return int'((mix + 32768) >> (SW - DBW));
   endfunction

   always @(negedge CLK) begin
      if (!RESET) begin
         if (SAMPLE_REQ) begin
            exp_q.push_back(model(SRC_DATA, SRC_VOL, SRC_MUTE));
            req_q.push_back(cyc);
            n_req++;
            if (chk_period && last_req >= 0)
               check("req_period", cyc - last_req, 20);
            last_req = cyc;
         end
         if (DAC_STROBE) begin
            n_strobe++;
            if (exp_q.size() == 0)
               check("unexp_strobe", DAC_STROBE, 0);
            else begin
               check("dac_value", DAC_VALUE, exp_q.pop_front());
               check("strobe_lat", cyc - req_q.pop_front(), 6);
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_ticks(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         TICK_EN = 1'b1;
         step();
         TICK_EN = 1'b0;
         repeat (gap - 1) step();
      end
   endtask

   task automatic wait_strobes(input int target);
      for (int i = 0; i < 60 && n_strobe < target; i++) step();
      check("strobe_seen", n_strobe, target);
   endtask

   task automatic wait_req(input int target);
      for (int i = 0; i < 60 && n_req < target; i++) step();
      check("req_seen", n_req, target);
   endtask

   task automatic set_src(input int i, input logic [SW-1:0] d, input logic [VW-1:0] v,
                          input logic mu);
      SRC_DATA[i*SW +: SW] = d;
      SRC_VOL[i*VW +: VW]  = v;
      SRC_MUTE[i]          = mu;
   endtask

   task automatic one_sample();
      int base;
      base = n_strobe;
      run_ticks(DIV, 2);
      wait_strobes(base + 1);
   endtask

   initial begin
      int base_s;
      int base_r;

      // Reset with TICK_EN active: ticks must be ignored.
      RESET = 1'b1;
      TICK_EN = 1'b1;
      repeat (3) step();
      RESET = 1'b0;
      TICK_EN = 1'b0;
      @(negedge CLK);
      check("rst_dac", DAC_VALUE, 512);
      check("rst_strobe", DAC_STROBE, 0);
      check("rst_busy", BUSY, 0);
      check("rst_overrun", OVERRUN, 0);
      check("rst_req", SAMPLE_REQ, 0);

      // Scheduling: tick every 4 clocks, one source at 0x4000 full volume.
      SRC_MUTE = '1;
      set_src(0, 16'h4000, 4'd15, 1'b0);
      chk_period = 1'b1;
      base_s = n_strobe;
      run_ticks(3 * DIV, 4);
      wait_strobes(base_s + 3);
      chk_period = 1'b0;
      check("sched_overrun", OVERRUN, 0);

      // Single negative source at half volume.
      SRC_MUTE = '1;
      set_src(1, 16'hE000, 4'd8, 1'b0);
      one_sample();

      // Positive and negative saturation.
      for (int i = 0; i < NS; i++) set_src(i, 16'h7FFF, 4'd15, 1'b0);
      one_sample();
      check("sat_hi", DAC_VALUE, 1023);
      for (int i = 0; i < NS; i++) set_src(i, 16'h8000, 4'd15, 1'b0);
      one_sample();
      check("sat_lo", DAC_VALUE, 0);

      // Snapshot: change src0 while the MAC is running.
      SRC_MUTE = '1;
      set_src(0, 16'h4000, 4'd15, 1'b0);
      base_s = n_strobe;
      base_r = n_req;
      run_ticks(DIV, 2);
      wait_req(base_r + 1);
      step();
      set_src(0, 16'h7FFF, 4'd15, 1'b0);
      wait_strobes(base_s + 1);
      check("snap_hold", DAC_VALUE, 752);

      // Muted full-scale source next to a small live one.
      set_src(0, 16'h7FFF, 4'd15, 1'b1);
      set_src(2, 16'h1000, 4'd4, 1'b0);
      one_sample();

      // Overrun: TICK_EN held high gives a start every 5 clocks.
      SRC_MUTE = '1;
      set_src(0, 16'h4000, 4'd15, 1'b0);
      base_s = n_strobe;
      base_r = n_req;
      TICK_EN = 1'b1;
      repeat (2 * DIV) step();
      TICK_EN = 1'b0;
      wait_strobes(base_s + 1);
      check("ovr_set", OVERRUN, 1);
      check("ovr_one_req", n_req, base_r + 1);
      OVERRUN_CLR = 1'b1;
      step();
      OVERRUN_CLR = 1'b0;
      @(negedge CLK);
      check("ovr_clr", OVERRUN, 0);

      // Clear coinciding with a new overrun: the set must win.
      base_s = n_strobe;
      TICK_EN = 1'b1;
      for (int i = 0; i < 2 * DIV; i++) begin
         if (i == 2 * DIV - 1) OVERRUN_CLR = 1'b1;
         step();
      end
      TICK_EN = 1'b0;
      OVERRUN_CLR = 1'b0;
      @(negedge CLK);
      check("ovr_set_wins", OVERRUN, 1);
      wait_strobes(base_s + 1);

      // Reset during MAC: no strobe, midscale output, idle.
      base_s = n_strobe;
      base_r = n_req;
      run_ticks(DIV, 2);
      wait_req(base_r + 1);
      step();
      RESET = 1'b1;
      exp_q.delete();
      req_q.delete();
      step();
      @(negedge CLK);
      check("mid_rst_busy", BUSY, 0);
      check("mid_rst_dac", DAC_VALUE, 512);
      check("mid_rst_strobe", DAC_STROBE, 0);
      check("mid_rst_overrun", OVERRUN, 0);
      RESET = 1'b0;
      repeat (12) step();
      check("no_strobe_after_rst", n_strobe, base_s);

      check("sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got %0d expected %0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
